// File: rtl/dbg_ram_loader.sv
// rtl/dbg_ram_loader.sv - debug-side byte editor/writer for the 256-byte BRAM
// Holds the CPU while the operator edits a byte, writes it, then reads it back to verify.
module dbg_ram_loader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_qzt_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_pulse,
  input  logic              i_direction,
  input  logic              i_btn_next,
  input  logic              i_btn_commit,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_field,
  output logic [1:0]        o_status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_WRITE,
    S_WAIT_RD,
    S_CHECK
  } state_t;

  // rd_data shows the new address RD_LATENCY cycles after the change; one more edge to capture it
  localparam logic [2:0] LAT      = 3'(RD_LATENCY);
  localparam logic [2:0] LOAD_DLY = 3'(RD_LATENCY + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_OK   = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [2:0]          r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_cpu_hold;
  logic                r_field;
  logic [1:0]          r_status;

  always_ff @(posedge i_qzt_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_field    <= 1'b0;
      r_status   <= ST_IDLE;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_state    <= S_EDIT;
            r_cpu_hold <= 1'b1;
            r_field    <= 1'b0;
            r_status   <= ST_IDLE;
            r_cnt      <= LOAD_DLY;
          end
        end
        S_EDIT: begin
          if (!i_en) begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b0;
            r_status   <= ST_IDLE;
            r_cnt      <= '0;
          end else if (i_btn_commit) begin
            r_state   <= S_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= r_data;
            r_status  <= ST_BUSY;
            r_cnt     <= LAT;
          end else begin
            if (r_cnt != 3'd0) begin
              r_cnt <= r_cnt - 3'd1;
              if (r_cnt == 3'd1) r_data <= i_rd_data;
            end
            // a data edit in the same cycle as a pending reload takes precedence
            if (i_pulse) begin
              if (!r_field) begin
                r_addr   <= i_direction ? r_addr + ADDR_W'(1) : r_addr - ADDR_W'(1);
                r_status <= ST_IDLE;
                r_cnt    <= LOAD_DLY;
              end else begin
                r_data <= i_direction ? r_data + DATA_W'(1) : r_data - DATA_W'(1);
              end
            end
            if (i_btn_next) r_field <= ~r_field;
          end
        end
        S_WRITE: begin
          r_state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (r_cnt <= 3'd1) begin
            r_state <= S_CHECK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_CHECK: begin
          r_status <= (i_rd_data == r_data) ? ST_OK : ST_ERR;
          r_cnt    <= '0;
          if (i_en) begin
            r_state <= S_EDIT;
          end else begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_addr  = r_addr;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cpu_hold = r_cpu_hold;
  assign o_field    = r_field;
  assign o_status   = r_status;

endmodule
